// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-lite core and its program loader:
// opcodes, instruction field layout and loader state encoding.
package mips_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [BYTE_W-1:0] OP_NOOP  = 8'h00;
    localparam logic [BYTE_W-1:0] OP_ADD   = 8'h01;
    localparam logic [BYTE_W-1:0] OP_SUB   = 8'h02;
    localparam logic [BYTE_W-1:0] OP_AND   = 8'h03;
    localparam logic [BYTE_W-1:0] OP_OR    = 8'h04;
    localparam logic [BYTE_W-1:0] OP_XOR   = 8'h05;
    localparam logic [BYTE_W-1:0] OP_LOAD  = 8'h06;
    localparam logic [BYTE_W-1:0] OP_STORE = 8'h07;
    localparam logic [BYTE_W-1:0] OP_JMP   = 8'h08;
    localparam logic [BYTE_W-1:0] OP_BEQ   = 8'h09;
    localparam logic [BYTE_W-1:0] OP_PUSH  = 8'h0A;
    localparam logic [BYTE_W-1:0] OP_POP   = 8'h0B;
    localparam logic [BYTE_W-1:0] OP_MAX   = OP_POP;

    // Bit positions of the instruction fields inside a 32-bit word.
    localparam int unsigned OP_LSB   = 24;
    localparam int unsigned DEST_LSB = 16;
    localparam int unsigned SRC1_LSB = 8;
    localparam int unsigned SRC2_LSB = 0;

    typedef struct packed {
        logic [BYTE_W-1:0] opcode;
        logic [BYTE_W-1:0] dest;
        logic [BYTE_W-1:0] src1;
        logic [BYTE_W-1:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    function automatic logic op_legal(input logic [BYTE_W-1:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Byte-to-word assembler: shifts payload bytes MSB first, tracks the byte
// index within the word and keeps the running XOR checksum.
module mips_word_pack
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [1:0]        byte_idx_o,
    output logic [BYTE_W-1:0] csum_o,
    output logic              word_valid_c,
    output instr_t            word_c
);

    logic [3*BYTE_W-1:0] shift_q, shift_d;
    logic [1:0]          idx_q, idx_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
            csum_d  = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[2*BYTE_W-1:0], byte_data};
            idx_d   = idx_q + 2'd1;
            csum_d  = csum_q ^ byte_data;
        end
    end

    // The fourth byte completes the word in the same cycle it arrives.
    assign word_valid_c = byte_valid && !clr && (idx_q == 2'd3);
    assign word_c       = instr_t'({shift_q, byte_data});
    assign byte_idx_o   = idx_q;
    assign csum_o       = csum_q;

endmodule

// File: rtl/mips_prog_loader.sv
// Program loader: receives a framed byte stream, writes instruction words into
// imem, validates the checksum and only then releases the CPU.
module mips_prog_loader
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  wl_q, wl_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              run_q, run_d;

    logic              xfer;
    logic              pack_clr;
    logic              pack_valid;
    logic [1:0]        byte_idx;
    logic [BYTE_W-1:0] csum;
    logic              word_valid;
    instr_t            word;

    assign s_ready    = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign xfer       = s_valid && s_ready;
    assign pack_valid = xfer && (state_q == ST_DATA);

    mips_word_pack u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (pack_clr),
        .byte_valid   (pack_valid),
        .byte_data    (s_data),
        .byte_idx_o   (byte_idx),
        .csum_o       (csum),
        .word_valid_c (word_valid),
        .word_c       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            wl_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wl_q    <= wl_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        wl_d     = wl_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pack_clr = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_HDR;
                    wl_d     = '0;
                    pack_clr = 1'b1;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if ((s_data == '0) || (s_data > BYTE_W'(DEPTH))) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = CNT_W'(s_data);
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if ((byte_idx == 2'd0) && !op_legal(s_data)) begin
                        state_d = ST_ERR;
                    end else if (word_valid) begin
                        we_d    = 1'b1;
                        addr_d  = wl_q[ADDR_W-1:0];
                        wdata_d = word;
                        wl_d    = wl_q + CNT_W'(1);
                        if ((wl_q + CNT_W'(1)) == n_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (s_data == csum) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status levels follow the state being entered.
        done_d = (state_d == ST_DONE);
        run_d  = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_run      = run_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_mips_prog_loader;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  words_loaded;

    int checks = 0;
    int failures = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    logic [7:0]  frame[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
    int          exp_consumed;

    mips_prog_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Every write strobe seen on the memory port.
    always @(negedge clk) begin
        if (rst_n && imem_we) got_q.push_back({imem_addr, imem_wdata});
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        for (int c = 0; c < 50; c++) begin
            if (s_ready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: s_ready stayed 0, byte %02h required to transfer", b);
    endtask

    task automatic send_frame(input int count, input bit stall);
        for (int i = 0; i < count; i++) begin
            if (stall && ($urandom_range(0, 1) == 1)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_byte(frame[i]);
        end
        s_valid = 1'b0;
    endtask

    // Frame builder: bad_word >= 0 plants an illegal opcode in that word.
    task automatic build_frame(input int n, input int bad_word, input logic [7:0] corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            b = (w == bad_word) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(0, 11));
            frame.push_back(b);
            cs = cs ^ b;
            for (int k = 0; k < 3; k++) begin
                b = 8'($urandom_range(0, 255));
                frame.push_back(b);
                cs = cs ^ b;
            end
        end
        frame.push_back(cs ^ corrupt);
    endtask

    // Reference: interprets the frame by the protocol rules.
    task automatic model_frame();
        int n;
        logic [7:0]  cs;
        logic [31:0] w32;
        logic [4:0]  a;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_words = 0;
        exp_consumed = 1;
        n = int'(frame[0]);
        if (n == 0 || n > 32) begin
            exp_err = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_consumed++;
            if (frame[1+4*w] > 8'h0B) begin
                exp_err = 1'b1;
                return;
            end
            w32 = {frame[1+4*w], frame[2+4*w], frame[3+4*w], frame[4+4*w]};
            cs = cs ^ frame[1+4*w] ^ frame[2+4*w] ^ frame[3+4*w] ^ frame[4+4*w];
            exp_consumed += 3;
            a = 5'(w);
            exp_q.push_back({a, w32});
            exp_words++;
        end
        exp_consumed++;
        if (frame[1+4*n] == cs) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_run, done, err, words_loaded, s_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: we=%0b addr=%0d wdata=%08h run=%0b done=%0b err=%0b wl=%0d rdy=%0b, all 0 required",
                     imem_we, imem_addr, imem_wdata, cpu_run, done, err, words_loaded, s_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good_load();
        got_q.delete();
        frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'h08};
        pulse_start();
        send_frame(10, 1'b0);
        settle();
        checks++;
        if (got_q.size() != 2) begin
            failures++;
            $display("FAIL good_write_count: got %0d writes, 2 required", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {5'd0, 32'h01000000}) begin
                failures++;
                $display("FAIL good_word0: got %010h, %010h required", got_q[0], {5'd0, 32'h01000000});
            end
            checks++;
            if (got_q[1] !== {5'd1, 32'h08010000}) begin
                failures++;
                $display("FAIL good_word1: got %010h, %010h required", got_q[1], {5'd1, 32'h08010000});
            end
        end
        checks++;
        if ({done, cpu_run, err, words_loaded} !== {1'b1, 1'b1, 1'b0, 6'd2}) begin
            failures++;
            $display("FAIL good_status: done=%0b run=%0b err=%0b wl=%0d, 1 1 0 2 required", done, cpu_run, err, words_loaded);
        end
        // Bytes offered in DONE must be ignored.
        s_valid = 1'b1;
        s_data = 8'h05;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b0;
        checks++;
        if ({done, s_ready, words_loaded, got_q.size() == 2} !== {1'b1, 1'b0, 6'd2, 1'b1}) begin
            failures++;
            $display("FAIL done_ignores_bytes: done=%0b rdy=%0b wl=%0d writes=%0d, 1 0 2 2 required", done, s_ready, words_loaded, got_q.size());
        end
        pulse_start();
        checks++;
        if ({cpu_run, done, words_loaded, s_ready} !== {1'b0, 1'b0, 6'd0, 1'b1}) begin
            failures++;
            $display("FAIL restart_from_done: run=%0b done=%0b wl=%0d rdy=%0b, 0 0 0 1 required", cpu_run, done, words_loaded, s_ready);
        end
    endtask

    task automatic test_bad_csum();
        got_q.delete();
        frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'h09};
        pulse_start();
        send_frame(10, 1'b0);
        settle();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {5'd0, 32'h01000000} || got_q[1] !== {5'd1, 32'h08010000}) begin
            failures++;
            $display("FAIL badcsum_writes: got %0d writes, 2 writes (0:01000000 1:08010000) required", got_q.size());
        end
        checks++;
        if ({err, cpu_run, done} !== 3'b100) begin
            failures++;
            $display("FAIL badcsum_status: err=%0b run=%0b done=%0b, 1 0 0 required", err, cpu_run, done);
        end
    endtask

    task automatic test_bad_opcode();
        got_q.delete();
        frame = '{8'h01, 8'h0C};
        pulse_start();
        send_frame(2, 1'b0);
        checks++;
        if ({err, s_ready, cpu_run} !== 3'b100) begin
            failures++;
            $display("FAIL badop_status: err=%0b rdy=%0b run=%0b, 1 0 0 required", err, s_ready, cpu_run);
        end
        settle();
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL badop_no_write: got %0d writes, 0 required", got_q.size());
        end
    endtask

    task automatic test_header_bounds();
        frame = '{8'h00};
        pulse_start();
        send_frame(1, 1'b0);
        checks++;
        if ({err, done} !== 2'b10) begin
            failures++;
            $display("FAIL hdr_zero: err=%0b done=%0b, 1 0 required", err, done);
        end
        frame = '{8'h21};
        pulse_start();
        send_frame(1, 1'b0);
        checks++;
        if ({err, done} !== 2'b10) begin
            failures++;
            $display("FAIL hdr_33: err=%0b done=%0b, 1 0 required", err, done);
        end
        got_q.delete();
        build_frame(32, -1, 8'h00);
        model_frame();
        pulse_start();
        send_frame(exp_consumed, 1'b0);
        settle();
        checks++;
        if (got_q.size() != 32 || got_q != exp_q) begin
            failures++;
            $display("FAIL hdr_32_writes: got %0d writes, 32 matching the frame required", got_q.size());
        end else begin
            checks++;
            if (got_q[31][36:32] !== 5'd31) begin
                failures++;
                $display("FAIL hdr_32_last_addr: got %0d, 31 required", got_q[31][36:32]);
            end
        end
        checks++;
        if ({done, cpu_run, words_loaded} !== {1'b1, 1'b1, 6'd32}) begin
            failures++;
            $display("FAIL hdr_32_status: done=%0b run=%0b wl=%0d, 1 1 32 required", done, cpu_run, words_loaded);
        end
    endtask

    task automatic test_stall();
        logic [7:0] pay[4];
        pay = '{8'h03, 8'h02, 8'h01, 8'h00};
        got_q.delete();
        pulse_start();
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) begin
            send_byte(pay[i]);
            s_valid = 1'b0;
            if (i == 1) pulse_start();
            else begin
                @(posedge clk); #1;
            end
        end
        send_byte(8'h00);
        s_valid = 1'b0;
        settle();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {5'd0, 32'h03020100}) begin
            failures++;
            $display("FAIL stall_write: got %0d writes, one write 0:03020100 required", got_q.size());
        end
        checks++;
        if ({done, err, words_loaded} !== {1'b1, 1'b0, 6'd1}) begin
            failures++;
            $display("FAIL stall_status: done=%0b err=%0b wl=%0d, 1 0 1 required", done, err, words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01};
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(frame[i]);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_run, done, err, words_loaded, s_ready} !== '0) begin
            failures++;
            $display("FAIL reset_mid: we=%0b addr=%0d wdata=%08h run=%0b done=%0b err=%0b wl=%0d rdy=%0b, all 0 required",
                     imem_we, imem_addr, imem_wdata, cpu_run, done, err, words_loaded, s_ready);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'h08};
        pulse_start();
        send_frame(10, 1'b0);
        settle();
        checks++;
        if ({done, words_loaded, got_q.size() == 2} !== {1'b1, 6'd2, 1'b1}) begin
            failures++;
            $display("FAIL reset_recover: done=%0b wl=%0d writes=%0d, 1 2 2 required", done, words_loaded, got_q.size());
        end
    endtask

    task automatic test_random();
        int n;
        int bad;
        int sel;
        logic [7:0] corrupt;
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, 8));
            bad = (sel == 1) ? int'($urandom_range(0, n - 1)) : -1;
            corrupt = (sel == 2) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            build_frame(n, bad, corrupt);
            if (sel == 3) frame[0] = 8'h00;
            if (sel == 4) frame[0] = 8'($urandom_range(33, 255));
            model_frame();
            got_q.delete();
            pulse_start();
            send_frame(exp_consumed, 1'b1);
            settle();
            checks++;
            if (got_q != exp_q) begin
                failures++;
                $display("FAIL rand_writes[%0d]: got %0d writes, %0d matching writes required", it, got_q.size(), exp_q.size());
            end
            checks++;
            if ({done, err, cpu_run, words_loaded} !== {exp_done, exp_err, exp_done, 6'(exp_words)}) begin
                failures++;
                $display("FAIL rand_status[%0d]: done=%0b err=%0b run=%0b wl=%0d, %0b %0b %0b %0d required",
                         it, done, err, cpu_run, words_loaded, exp_done, exp_err, exp_done, exp_words);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_bad_opcode();
        test_header_bounds();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Writer-side counterpart to the CPU's instruction fetch. It receives a program as a byte stream on a valid/ready interface and assembles each group of four bytes into a 32-bit instruction word {opcode, dest, src1, src2}. It writes each word into the 32-entry instruction memory and checks the load, then releases the CPU by asserting cpu_run. It sits between the bench/host link and the instruction memory write port, and holds the CPU until the image is validated.

Parameters:
ADDR_W, 5, instruction memory address width
DEPTH, 32, instruction memory depth in words (2**ADDR_W)
OP_MAX, 8'h0B, highest legal opcode (POP)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load (honoured in IDLE, DONE, ERR only)
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  instruction memory write address
imem_wdata  output  32  instruction word
cpu_run  output  1  CPU fetch enable; high only in DONE
done  output  1  load completed with good checksum (level)
err  output  1  load aborted (level, sticky until start/reset)
words_loaded  output  ADDR_W+1  count of words written in current load

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. On reset, all outputs are 0 and the state is IDLE. Instruction memory contents are not cleared.
- Handshake: a byte transfers when s_valid && s_ready on a rising edge. s_ready is combinational from state: 1 in HDR, DATA and CSUM; 0 otherwise. s_data is ignored when no transfer occurs.
- Frame format: the header byte N gives the word count, followed by 4*N payload bytes (MSB first: opcode, dest, src1, src2), then one checksum byte equal to the XOR of all payload bytes. The header is not included in the checksum.
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE: start moves to HDR on the next cycle and clears words_loaded, the checksum accumulator, the byte index, done, err and cpu_run.
- HDR: a header with N==0 or N>DEPTH goes to ERR. Otherwise N is latched and the state moves to DATA.
- DATA: each transferred byte shifts into the word register and XORs into the checksum. A 2-bit byte index wraps 3->0.
  - On the transfer of byte index 3, the cycle after the transfer has imem_we=1, imem_addr=word index, imem_wdata=assembled word, and words_loaded increments.
  - imem_we is high for exactly one cycle per word. s_ready stays high, so back-to-back bytes sustain one word per 4 cycles.
  - If the opcode byte (index 0) is greater than OP_MAX, the state goes to ERR immediately and the word is not written.
  - After word N-1 is accepted, the state moves to CSUM.
- CSUM: a received byte equal to the accumulator goes to DONE; otherwise the state goes to ERR.
- DONE: done=1, cpu_run=1. Further s_valid is ignored.
- ERR: err=1, cpu_run=0. Words already written remain in memory.
- start pulses in HDR, DATA or CSUM are ignored. A start in DONE or ERR restarts the load (cpu_run drops on the next cycle).
- Simultaneous events: a start pulse and a byte transfer cannot coincide, because s_ready=0 in every state that honours start.
- Reset mid-load: the state returns to IDLE and all outputs clear. The pending write strobe is cancelled.
- imem_addr wraps naturally within ADDR_W. The DEPTH check prevents any overrun.

Decomposition:
- Shared package mips_pkg: opcode constants NOOP..POP (8'h0..8'hB), OP_MAX, instruction field slice constants, and the loader state enum.
- One natural sub-module, mips_word_pack: byte shifter, byte index, and running XOR checksum. It outputs word_valid (pulse) and the word.
- The FSM and the memory port stay in the top module.

Test Plan:
- Good load: start, then bytes 02, 01 00 00 00, 08 01 00 00, checksum 08. Required response:
  - imem_we twice: addr0 = 0x01000000, addr1 = 0x08010000.
  - done=1, cpu_run=1, words_loaded=2.
- Bad checksum: same frame with checksum 09 -> both words written, then err=1, cpu_run=0, done=0.
- Illegal opcode: header 01, first byte 0C -> err=1 the next cycle, no imem_we, s_ready=0.
- Header bounds: header 00 -> ERR; header 21 (33) -> ERR; header 20 with 128 bytes and correct checksum -> 32 writes, last at addr 31, DONE.
- Stalled stream: s_valid toggled every other cycle during a 1-word load -> the word is still written once, correctly. Additionally, a start pulse in DATA is ignored.
- Reset mid-DATA: rst_n low after 6 payload bytes -> all outputs 0 immediately. A subsequent start plus a good frame completes with done=1.
